// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain sequencing controller.
package scan_pkg;

    localparam int unsigned DEFAULT_CHAIN_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, right-shifting register; serial data enters at the MSB, leaves at the LSB.
module scan_shift_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // Load takes priority over shift
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (shift) begin
            data_q <= {serial_in, data_q[WIDTH-1:1]};
        end
    end

    assign serial_out = data_q[0];
    assign data_o     = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test sequencer: shift a pattern in, pulse one capture, shift the chain back out.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 abort,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 capture_en,
    output logic                 busy,
    output logic [CHAIN_LEN-1:0] result,
    output logic                 done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_ready_q, start_ready_d;
    logic                 busy_q, busy_d;
    logic                 scan_en_q, scan_en_d;
    logic                 capture_en_q, capture_en_d;
    logic                 done_q, done_d;
    logic [CHAIN_LEN-1:0] result_q;

    logic                 accept;
    logic                 abort_hit;
    logic                 last_bit;
    logic [CHAIN_LEN-1:0] rx_data;
    logic [CHAIN_LEN-1:0] tx_data_unused;
    logic                 rx_serial_unused;
    logic                 rx_lsb_unused;

    assign accept    = start && start_ready_q;
    assign abort_hit = abort && (state_q != ST_IDLE);
    assign last_bit  = (cnt_q == LAST_CNT);

    // State and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            scan_en_q     <= 1'b0;
            capture_en_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            scan_en_q     <= scan_en_d;
            capture_en_q  <= capture_en_d;
            done_q        <= done_d;
        end
    end

    // Next state and bit counter; abort overrides any other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_SHIFT_IN;
            end
            ST_SHIFT_IN: begin
                if (last_bit) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: state_d = ST_SHIFT_OUT;
            ST_SHIFT_OUT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Output decode from the upcoming state so the registered outputs track it
    always_comb begin
        start_ready_d = 1'b0;
        busy_d        = 1'b1;
        scan_en_d     = 1'b0;
        capture_en_d  = 1'b0;
        done_d        = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                start_ready_d = 1'b1;
                busy_d        = 1'b0;
            end
            ST_SHIFT_IN:  scan_en_d    = 1'b1;
            ST_CAPTURE:   capture_en_d = 1'b1;
            ST_SHIFT_OUT: scan_en_d    = 1'b1;
            ST_DONE:      done_d       = 1'b1;
            default:      busy_d       = 1'b1;
        endcase
    end

    // TX is cleared on abort so scan_in idles low
    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_tx (
        .clk        (clk),
        .resetn     (resetn),
        .load       (accept || abort_hit),
        .load_data  (accept ? pattern_in : '0),
        .shift      (state_q == ST_SHIFT_IN),
        .serial_in  (1'b0),
        .serial_out (scan_in),
        .data_o     (tx_data_unused)
    );

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .load       (accept),
        .load_data  ('0),
        .shift      (state_q == ST_SHIFT_OUT),
        .serial_in  (scan_out),
        .serial_out (rx_serial_unused),
        .data_o     (rx_data)
    );

    assign rx_lsb_unused = rx_data[0];

    // Result takes RX's post-edge value on the edge entering DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
        end else if (state_d == ST_DONE) begin
            result_q <= {scan_out, rx_data[CHAIN_LEN-1:1]};
        end
    end

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign scan_en     = scan_en_q;
    assign capture_en  = capture_en_q;
    assign done        = done_q;
    assign result      = result_q;

endmodule
